// File: rtl/imm_pkg.sv
//------------------------------------------------------------------------------
// Module   : imm_pkg
// Purpose  : Opcode constants and format codes shared by the immediate generator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package imm_pkg;

    localparam int c_FMT_W = 3;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;

    localparam logic [2:0] c_F3_SLL = 3'b001;
    localparam logic [2:0] c_F3_SRX = 3'b101;

    typedef enum logic [c_FMT_W-1:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_SH      = 3'd6,
        FMT_ILLEGAL = 3'd7
    } fmt_t;

endpackage

`default_nettype wire

// File: rtl/imm_decode.sv
//------------------------------------------------------------------------------
// Module   : imm_decode
// Purpose  : Combinational RV32I/RV64I immediate decode and sign extension.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit BYTE_OFFSET = 1'b1
) (
    input  logic [31:0]      i_instr,
    output logic [XLEN-1:0]  o_imm,
    output fmt_t             o_fmt
);

    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_sh;

    assign w_imm_i = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};

    generate
        if (BYTE_OFFSET) begin : g_byte_units
            assign w_imm_b = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            assign w_imm_j = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
        end else begin : g_half_units
            assign w_imm_b = {{(XLEN-12){i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8]};
            assign w_imm_j = {{(XLEN-20){i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21]};
        end
    endgenerate

    // RV64 widens shamt to 6 bits; funct7 never leaks into the immediate.
    generate
        if (XLEN == 64) begin : g_xlen64
            assign w_imm_u  = {{(XLEN-32){i_instr[31]}}, i_instr[31:12], 12'h000};
            assign w_imm_sh = {{(XLEN-6){1'b0}}, i_instr[25:20]};
        end else begin : g_xlen32
            assign w_imm_u  = {i_instr[31:12], 12'h000};
            assign w_imm_sh = {{(XLEN-5){1'b0}}, i_instr[24:20]};
        end
    endgenerate

    always_comb begin
        o_imm = '0;
        o_fmt = FMT_ILLEGAL;
        case (i_instr[6:0])
            c_OPC_OP: begin
                o_fmt = FMT_R;
            end
            c_OPC_LOAD, c_OPC_JALR, c_OPC_SYSTEM: begin
                o_fmt = FMT_I;
                o_imm = w_imm_i;
            end
            c_OPC_OP_IMM: begin
                if ((i_instr[14:12] == c_F3_SLL) || (i_instr[14:12] == c_F3_SRX)) begin
                    o_fmt = FMT_SH;
                    o_imm = w_imm_sh;
                end else begin
                    o_fmt = FMT_I;
                    o_imm = w_imm_i;
                end
            end
            c_OPC_STORE: begin
                o_fmt = FMT_S;
                o_imm = w_imm_s;
            end
            c_OPC_BRANCH: begin
                o_fmt = FMT_B;
                o_imm = w_imm_b;
            end
            c_OPC_LUI, c_OPC_AUIPC: begin
                o_fmt = FMT_U;
                o_imm = w_imm_u;
            end
            c_OPC_JAL: begin
                o_fmt = FMT_J;
                o_imm = w_imm_j;
            end
            default: begin
                o_fmt = FMT_ILLEGAL;
                o_imm = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
//------------------------------------------------------------------------------
// Module   : imm_gen_pipe
// Purpose  : Registered immediate generator with ready/valid stage and 2-entry skid.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TAG_W       = 32,
    parameter bit BYTE_OFFSET = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       fmt_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_out_valid;
    logic             r_in_ready;

    logic [XLEN-1:0]  r_out_imm;
    fmt_t             r_out_fmt;
    logic [TAG_W-1:0] r_out_tag;
    logic [XLEN-1:0]  r_skid_imm;
    fmt_t             r_skid_fmt;
    logic [TAG_W-1:0] r_skid_tag;

    logic [XLEN-1:0]  w_dec_imm;
    fmt_t             w_dec_fmt;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_out;
    logic             w_load_skid;
    logic             w_skid_to_out;

    imm_decode #(
        .XLEN        (XLEN),
        .BYTE_OFFSET (BYTE_OFFSET)
    ) u_decode (
        .i_instr (instr_i),
        .o_imm   (w_dec_imm),
        .o_fmt   (w_dec_fmt)
    );

    assign w_in_fire  = in_valid_i & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= c_ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != c_ST_EMPTY);
            r_in_ready  <= (w_state_nxt != c_ST_FULL);
        end
    end

    // Flush takes priority over any transfer presented in the same cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        if (flush_i) begin
            w_state_nxt = c_ST_EMPTY;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = c_ST_ONE;
                        w_load_out  = 1'b1;
                    end
                end
                c_ST_ONE: begin
                    case ({w_in_fire, w_out_fire})
                        2'b11: w_load_out = 1'b1;
                        2'b01: w_state_nxt = c_ST_EMPTY;
                        2'b10: begin
                            w_state_nxt = c_ST_FULL;
                            w_load_skid = 1'b1;
                        end
                        default: w_state_nxt = c_ST_ONE;
                    endcase
                end
                c_ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt   = c_ST_ONE;
                        w_skid_to_out = 1'b1;
                    end
                end
                default: w_state_nxt = c_ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_out_imm  <= '0;
            r_out_fmt  <= FMT_R;
            r_out_tag  <= '0;
            r_skid_imm <= '0;
            r_skid_fmt <= FMT_R;
            r_skid_tag <= '0;
        end else begin
            if (w_load_out) begin
                r_out_imm <= w_dec_imm;
                r_out_fmt <= w_dec_fmt;
                r_out_tag <= tag_i;
            end else if (w_skid_to_out) begin
                r_out_imm <= r_skid_imm;
                r_out_fmt <= r_skid_fmt;
                r_out_tag <= r_skid_tag;
            end
            if (w_load_skid) begin
                r_skid_imm <= w_dec_imm;
                r_skid_fmt <= w_dec_fmt;
                r_skid_tag <= tag_i;
            end
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign imm_o       = r_out_imm;
    assign fmt_o       = r_out_fmt;
    assign tag_o       = r_out_tag;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
//------------------------------------------------------------------------------
// Module   : tb_imm_gen_pipe
// Purpose  : Self-checking bench: queue-based reference model plus directed vectors.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] instr, tag;

    // main instance: XLEN=32, byte offsets
    logic        in_ready, out_valid;
    logic [31:0] imm, tag_out;
    logic [2:0]  fmt;
    // halfword-unit instance
    logic        h_in_ready, h_out_valid;
    logic [31:0] h_imm, h_tag;
    logic [2:0]  h_fmt;
    // 64-bit instance
    logic        x_in_ready, x_out_valid;
    logic [63:0] x_imm;
    logic [31:0] x_tag;
    logic [2:0]  x_fmt;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .BYTE_OFFSET(1'b1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .instr_i(instr), .tag_i(tag), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .imm_o(imm), .fmt_o(fmt), .tag_o(tag_out));

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .BYTE_OFFSET(1'b0)) dut_h (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(h_in_ready), .instr_i(instr), .tag_i(tag), .out_valid_o(h_out_valid),
        .out_ready_i(out_ready), .imm_o(h_imm), .fmt_o(h_fmt), .tag_o(h_tag));

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .BYTE_OFFSET(1'b1)) dut_x (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(x_in_ready), .instr_i(instr), .tag_i(tag), .out_valid_o(x_out_valid),
        .out_ready_i(out_ready), .imm_o(x_imm), .fmt_o(x_fmt), .tag_o(x_tag));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the ISA field definitions.
    function automatic void model(input logic [31:0] ins, input bit x64, input bit bo,
                                  output logic [63:0] imm_e, output logic [2:0] fmt_e);
        longint            v;
        logic signed [12:0] b;
        logic signed [20:0] j;
        v = 0;
        fmt_e = 3'd7;
        b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        case (ins[6:0])
            7'h33: fmt_e = 3'd0;
            7'h03, 7'h67, 7'h73: begin fmt_e = 3'd1; v = longint'($signed(ins[31:20])); end
            7'h13: begin
                if (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) begin
                    fmt_e = 3'd6;
                    v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
                end else begin
                    fmt_e = 3'd1;
                    v = longint'($signed(ins[31:20]));
                end
            end
            7'h23: begin fmt_e = 3'd2; v = longint'($signed({ins[31:25], ins[11:7]})); end
            7'h63: begin fmt_e = 3'd3; v = bo ? longint'(b) : longint'(b) / 2; end
            7'h37, 7'h17: begin fmt_e = 3'd4; v = longint'($signed({ins[31:12], 12'h000})); end
            7'h6F: begin fmt_e = 3'd5; v = bo ? longint'(j) : longint'(j) / 2; end
            default: begin fmt_e = 3'd7; v = 0; end
        endcase
        imm_e = x64 ? 64'(v) : {32'h0, v[31:0]};
    endfunction

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] tg;
    } ent_t;

    ent_t        q[$];
    logic [31:0] got[$];

    // Behavioural stage: a FIFO of depth two with pop-then-push per edge.
    always @(posedge clk or negedge rst_n) begin
        int n;
        if (!rst_n) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            n = q.size();
            if (n > 0 && out_ready) void'(q.pop_front());
            if (in_valid && n < 2) q.push_back('{ins: instr, tg: tag});
        end
    end

    always @(posedge clk)
        if (rst_n && !flush && out_valid && out_ready) got.push_back(tag_out);

    always @(negedge clk) begin
        logic [63:0] ei;
        logic [2:0]  ef;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_imm", imm, 0);
            chk("rst_fmt", fmt, 0);
            chk("rst_tag", tag_out, 0);
        end else begin
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, q.size() < 2);
            chk("h_out_valid", h_out_valid, q.size() != 0);
            chk("h_in_ready", h_in_ready, q.size() < 2);
            chk("x_out_valid", x_out_valid, q.size() != 0);
            chk("x_in_ready", x_in_ready, q.size() < 2);
            if (q.size() != 0) begin
                model(q[0].ins, 1'b0, 1'b1, ei, ef);
                chk("imm", imm, ei);
                chk("fmt", fmt, ef);
                chk("tag", tag_out, q[0].tg);
                model(q[0].ins, 1'b0, 1'b0, ei, ef);
                chk("h_imm", h_imm, ei);
                chk("h_fmt", h_fmt, ef);
                chk("h_tag", h_tag, q[0].tg);
                model(q[0].ins, 1'b1, 1'b1, ei, ef);
                chk("x_imm", x_imm, ei);
                chk("x_fmt", x_fmt, ef);
                chk("x_tag", x_tag, q[0].tg);
            end
        end
    end

    task automatic push(input logic [31:0] ins, input logic [31:0] tg);
        bit acc;
        acc = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        instr = ins;
        tag = tg;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("push_accept", acc, 1);
    endtask

    logic [31:0] tbl[13] = '{32'hFFF00093, 32'hFE112E23, 32'h0040006F, 32'hFFDFF06F,
                             32'hFFFFF097, 32'h00109093, 32'h03F0D093, 32'h80002083,
                             32'h000080E7, 32'h00000073, 32'h002081B3, 32'h0000007F,
                             32'h0000000F};

    initial begin
        logic [63:0] mi;
        logic [2:0]  mf;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; tag = '0;

        // model pins against hand-derived values
        model(32'hFE000EE3, 1'b1, 1'b0, mi, mf);
        chk("pin_beq_half64", mi, 64'hFFFF_FFFF_FFFF_FFFE);
        model(32'h4030D093, 1'b1, 1'b1, mi, mf);
        chk("pin_srai64", {mi[60:0], mf}, {61'd3, 3'd6});
        model(32'hFFDFF06F, 1'b0, 1'b1, mi, mf);
        chk("pin_jal_m4", mi, 64'h0000_0000_FFFF_FFFC);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        push(32'hFFF00093, 32'hA0);
        @(negedge clk);
        chk("addi_fmt", fmt, 1);
        chk("addi_imm", imm, 32'hFFFF_FFFF);
        chk("addi_tag", tag_out, 32'hA0);

        push(32'hFE000EE3, 32'hA1);
        @(negedge clk);
        chk("beq_fmt", fmt, 3);
        chk("beq_imm_byte", imm, 32'hFFFF_FFFC);
        chk("beq_imm_half", h_imm, 32'hFFFF_FFFE);

        push(32'h4030D093, 32'hA2);
        @(negedge clk);
        chk("srai_fmt", fmt, 6);
        chk("srai_imm", imm, 3);

        push(32'h123450B7, 32'hA3);
        @(negedge clk);
        chk("lui_fmt", fmt, 4);
        chk("lui_imm", imm, 32'h1234_5000);

        push(32'h800000B7, 32'hA4);
        @(negedge clk);
        chk("lui64_imm", x_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui32_imm", imm, 32'h8000_0000);

        push(32'h0000007F, 32'hA5);
        @(negedge clk);
        chk("illegal_fmt", fmt, 7);
        chk("illegal_imm", imm, 0);
        chk("illegal_no_x", $isunknown({imm, fmt, tag_out, out_valid, in_ready, x_imm, h_imm}), 0);

        // streamed table with occasional single-cycle stalls
        for (int i = 0; i < 13; i++) begin
            out_ready = (i % 3 != 0);
            push(tbl[i], 32'd200 + 32'(i));
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);

        // backpressure: A in output, B in skid, C held off
        #1;
        got.delete();
        out_ready = 1'b0;
        push(32'h00100093, 32'd1);
        push(32'h00200113, 32'd2);
        @(posedge clk); #1;
        in_valid = 1'b1; instr = 32'h00300193; tag = 32'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold_tag", tag_out, 1);
            chk("bp_hold_imm", imm, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        push(32'h00300193, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_count", got.size(), 3);
        for (int k = 0; k < 3 && k < got.size(); k++) chk("bp_order", got[k], 32'(k + 1));

        // flush from FULL with a live input
        out_ready = 1'b0;
        push(32'h00400213, 32'd4);
        push(32'h00500293, 32'd5);
        @(negedge clk);
        chk("fl_full", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; instr = 32'h00600313; tag = 32'd6;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        got.delete();
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("fl_dropped", got.size(), 0);

        // asynchronous reset in FULL, observed before the next edge
        out_ready = 1'b0;
        push(32'hFFF00393, 32'd7);
        push(32'h00800413, 32'd8);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_in_ready", in_ready, 1);
        chk("ar_imm", imm, 0);
        chk("ar_fmt", fmt, 0);
        chk("ar_tag", tag_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(32'hFFF00093, 32'd9);
        @(negedge clk);
        chk("ar_recover_tag", tag_out, 9);
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the ID stage. Decodes all RV32I/RV64I immediate formats (I, S, B, U, J, shift-amount) from a 32-bit instruction and sign-extends to `XLEN`. Delivers the result with a format code through a 1-cycle ready/valid pipeline stage with a 2-entry skid buffer. Sits between instruction fetch/IF-ID and the ALU/branch-target path, replacing the combinational 12-bit generator and external shifter.

## Interface
- `XLEN`, 32: output width. Legal values are 32 and 64.
- `TAG_W`, 32: width of the sideband tag (PC) carried alongside the instruction.
- `BYTE_OFFSET`, 1: controls B/J immediate units.
  - 1: B/J immediates are byte offsets, with bit 0 = 0 appended.
  - 0: B/J immediates are in halfword units.
- `clk_i` input 1: clock.
- `rst_n_i` input 1: reset, asynchronous, active-low.
- `flush_i` input 1: synchronous pipeline flush.
- `in_valid_i` input 1: instruction valid.
- `in_ready_o` output 1: stage can accept.
- `instr_i` input 32: instruction word.
- `tag_i` input TAG_W: sideband, passed through unchanged.
- `out_valid_o` output 1: result valid.
- `out_ready_i` input 1: consumer accepts.
- `imm_o` output XLEN: extended immediate.
- `fmt_o` output 3: format code.
- `tag_o` output TAG_W: tag of the current output.

## Operation
Decode is by `opcode = instr[6:0]`.
- **R**, opcode 0110011 → fmt R (0), imm 0.
- **I** (fmt 1), imm = sext(`instr[31:20]`). Applies to:
  - LOAD 0000011
  - JALR 1100111
  - SYSTEM 1110011
  - OP-IMM 0010011 with funct3 ∉ {001, 101}
- **SH** (fmt 6): OP-IMM with funct3 ∈ {001, 101}.
  - imm = zero-extended `instr[24:20]` when XLEN=32.
  - imm = zero-extended `instr[25:20]` when XLEN=64.
  - funct7 bits are never part of imm.
- **S** (fmt 2), opcode 0100011: imm = sext({`instr[31:25]`, `instr[11:7]`}).
- **B** (fmt 3), opcode 1100011: raw = {`instr[31]`, `instr[7]`, `instr[30:25]`, `instr[11:8]`}.
  - BYTE_OFFSET=1: imm = sext({raw, 0}).
  - BYTE_OFFSET=0: imm = sext(raw).
- **U** (fmt 4), opcodes 0110111 and 0010111: imm = sext({`instr[31:12]`, 12'b0}). Sign extension only matters for XLEN=64.
- **J** (fmt 5), opcode 1101111: raw = {`instr[31]`, `instr[19:12]`, `instr[20]`, `instr[30:21]`}. Same BYTE_OFFSET rule as B.
- **Any other opcode** → fmt ILLEGAL (7), imm 0. No X is ever driven.

Handshake rules:
- Input transfer happens on `in_valid_i & in_ready_o`.
- Output transfer happens on `out_valid_o & out_ready_i`.
- Order is preserved; no loss, no duplication.

## Timing
- **Latency:** accepted at edge N → visible on outputs after edge N, i.e. consumable in cycle N+1.
- **Throughput:** 1 per cycle while `out_ready_i`=1.
- **Skid FSM:** states EMPTY, ONE (output register full), FULL (output and skid full).
  - EMPTY + in → ONE.
  - ONE + in & out → ONE.
  - ONE + out & !in → EMPTY.
  - ONE + in & !out → FULL, with the new entry stored in skid.
  - FULL + out → ONE, skid moves to output.
- **Ready:** `in_ready_o` = !skid_valid, driven from a register with no combinational path from `out_ready_i`.
- **Output stability:** `imm_o`, `fmt_o` and `tag_o` are held stable while `out_valid_o` & !`out_ready_i`.
- **flush_i:**
  - At the next edge both valids clear and the FSM goes to EMPTY.
  - An input presented in the flush cycle is discarded.
  - `in_ready_o`=1 in the following cycle.
  - Flush overrides all simultaneous transfers.
- **Reset (`rst_n_i`=0, async, any state):**
  - FSM → EMPTY.
  - `out_valid_o`=0, `in_ready_o`=1.
  - `imm_o`=0, `fmt_o`=0, `tag_o`=0.
  - Skid contents are cleared.
  - Applies immediately, without waiting for a clock edge.

## Structure
- **Package `imm_pkg`:** RV opcode constants; `fmt_t` codes R=0, I=1, S=2, B=3, U=4, J=5, SH=6, ILLEGAL=7; width constant for `fmt_o`.
- **Sub-module `imm_decode`:** purely combinational, `instr` → {imm, fmt}, parametrised by XLEN and BYTE_OFFSET.
- **Top level:** decode at the input. Holds skid FSM, output register and skid register, each storing {imm, fmt, tag}.

## Test plan
- **addi:** `0xFFF00093` with XLEN=32 → next cycle fmt=1, imm=`0xFFFFFFFF`, tag echoed.
- **beq −4:** `0xFE000EE3` → fmt=3.
  - BYTE_OFFSET=1: imm=`0xFFFFFFFC`.
  - BYTE_OFFSET=0: imm=`0xFFFFFFFE`.
- **srai and lui:**
  - srai `0x4030D093` → fmt=6, imm=3 (not `0x403`).
  - lui `0x123450B7` → fmt=4, imm=`0x12345000`.
  - With XLEN=64, lui `0x800000B7` → imm=`0xFFFFFFFF80000000`.
- **Backpressure:** hold `out_ready_i`=0 and stream A, B, C.
  - Required: output holds A, B sits in skid, `in_ready_o`=0, C is held.
  - Release `out_ready_i` → A, B, C delivered in order, none duplicated.
- **Flush/reset in FULL state:**
  - `flush_i` with `in_valid_i`=1 → next cycle `out_valid_o`=0, `in_ready_o`=1, input dropped.
  - `rst_n_i` low mid-cycle → outputs zero before the next edge.
- **Illegal:** opcode `0x7F` (instr `0x0000007F`) → fmt=7, imm=0, no X on any output.
